pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core: turns stage stall requests into the
//  per-stage stall vector that gates the PC, if_id, id_ex, ex_mem and mem_wb registers.
//  On an exception it flushes every pipeline register for one cycle and redirects the PC.

---
 rtl/pipe_ctrl.sv | 94 +++++++++
 tb/tb_pipe_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-stage stall vector, exception
// flush/redirect with a short PC hold, and a sticky runaway-stall detector.
module pipe_ctrl #(
    parameter int FLUSH_HOLD = 1,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic [31:0]      excp_vector,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       HOLD_LD = 4'(FLUSH_HOLD);

    state_t     state;
    logic [3:0] hold_cnt;
    logic       any_req;

    assign any_req = stallreq_id | stallreq_ex | stallreq_mem;

    // Requests only shape the stall vector in RUN; mem outranks ex outranks id.
    always_comb begin
        stall = 6'b000000;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (stallreq_mem)     stall = 6'b011111;
                    else if (stallreq_ex) stall = 6'b001111;
                    else if (stallreq_id) stall = 6'b000111;
                end
                HOLD:    stall = 6'b000001;
                default: stall = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            flush         <= 1'b0;
            new_pc        <= 32'h0;
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
            hold_cnt      <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (any_req) begin
                        if (stall_cnt == TO_M1) stall_timeout <= 1'b1;
                        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
                    end else begin
                        stall_cnt <= '0;
                    end
                    // Exception overrides the run counter: entering FLUSH restarts it.
                    if (excp_valid) begin
                        state     <= FLUSH;
                        flush     <= 1'b1;
                        new_pc    <= excp_vector;
                        stall_cnt <= '0;
                    end
                end
                FLUSH: begin
                    flush     <= 1'b0;
                    stall_cnt <= '0;
                    hold_cnt  <= HOLD_LD;
                    state     <= (FLUSH_HOLD > 0) ? HOLD : RUN;
                end
                HOLD: begin
                    stall_cnt <= '0;
                    hold_cnt  <= hold_cnt - 4'd1;
                    if (hold_cnt <= 4'd1) state <= RUN;
                end
                default: begin
                    state <= RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed + randomized bench for pipe_ctrl against a cycle-level reference
// model that tracks "flush pending" / "hold cycles left" instead of FSM states.
module tb_pipe_ctrl;

    localparam int FH    = 1;
    localparam int TO    = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_id, stallreq_ex, stallreq_mem;
    logic             excp_valid;
    logic [31:0]      excp_vector;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit        m_flush;
    int        m_hold;
    bit [31:0] m_pc;
    int        m_cnt;
    bit        m_to;

    pipe_ctrl #(.FLUSH_HOLD(FH), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid), .excp_vector(excp_vector),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_timeout(stall_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [5:0] exp_stall();
        int depth;
        if (rst) return 6'd0;
        if (m_flush) return 6'd0;
        if (m_hold > 0) return 6'd1;
        depth = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : 0;
        return 6'((1 << depth) - 1);
    endfunction

    // Inputs are already applied; check mid-cycle, then advance the model across the edge.
    task automatic cycle();
        bit req;
        @(negedge clk);
        chk("stall", 32'(stall), 32'(exp_stall()));
        chk("flush", 32'(flush), 32'(m_flush));
        chk("new_pc", new_pc, m_pc);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        chk("timeout", 32'(stall_timeout), 32'(m_to));
        req = stallreq_id | stallreq_ex | stallreq_mem;
        if (rst) begin
            m_flush = 0; m_hold = 0; m_pc = 0; m_cnt = 0; m_to = 0;
        end else if (m_flush) begin
            m_flush = 0; m_hold = FH;
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            if (req) begin
                if (m_cnt == TO - 1) m_to = 1;
                m_cnt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
            end else m_cnt = 0;
            if (excp_valid) begin
                m_flush = 1; m_pc = excp_vector; m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit id, input bit ex, input bit mem,
                         input bit ev, input logic [31:0] vec);
        rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
        excp_valid = ev; excp_vector = vec;
    endtask

    initial begin
        m_flush = 0; m_hold = 0; m_pc = 0; m_cnt = 0; m_to = 0;
        drive(1, 0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        cycle();
        // idle after reset
        drive(0, 0, 0, 0, 0, 32'h0);
        repeat (10) cycle();
        // stall escalation then release
        drive(0, 1, 0, 0, 0, 0); cycle();
        drive(0, 1, 1, 0, 0, 0); cycle();
        drive(0, 1, 1, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("cnt_after_3", 32'(stall_cnt), 32'd3);
        cycle(); cycle();
        // exception with redirect and one hold cycle
        drive(0, 0, 0, 0, 1, 32'hBFC0_0380); cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("flush_pulse", 32'(flush), 32'd1);
        chk("redirect", new_pc, 32'hBFC0_0380);
        cycle();
        chk("hold_pc", 32'(stall), 32'd1);
        cycle(); cycle();
        // exception coinciding with mem stall; second exception during FLUSH ignored
        drive(0, 0, 0, 1, 1, 32'h8000_0180); cycle();
        drive(0, 0, 0, 1, 1, 32'h1234_5678); cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("excp_ignored", new_pc, 32'h8000_0180);
        repeat (3) cycle();
        // runaway stall
        drive(0, 0, 1, 0, 0, 0);
        repeat (3) cycle();
        chk("to_before", 32'(stall_timeout), 32'd0);
        cycle();
        chk("to_rise", 32'(stall_timeout), 32'd1);
        repeat (2) cycle();
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        // reset during HOLD
        drive(0, 0, 0, 0, 1, 32'hDEAD_BEE0); cycle();
        drive(0, 0, 0, 0, 0, 0); cycle();
        drive(1, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_hold_pc", new_pc, 32'h0);
        repeat (2) cycle();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0), $urandom);
            cycle();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
